// File: rtl/vip_morph_pkg.sv
// Shared encodings and helpers for the 1-bit morphology frame controller.
package vip_morph_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_ERODE  = 2'b01;
  localparam logic [1:0] MODE_DILATE = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // The reserved encoding is never put in force; it behaves as bypass.
  function automatic logic [1:0] mode_effective(input logic [1:0] mode);
    return (mode == MODE_RSVD) ? MODE_BYPASS : mode;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vip_edge_detect.sv
// Registers a 1-bit level and emits registered one-cycle rise/fall pulses.
module vip_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_level;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_level <= i_sig;
      r_rise  <= i_sig & ~r_level;
      r_fall  <= ~i_sig & r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/vip_morph_frame_ctrl.sv
// Frame controller for the 3x3 morphology unit: per-frame mode shadowing,
// pixel coordinate/border tracking and frame geometry checking.
module vip_morph_frame_ctrl
  import vip_morph_pkg::*;
#(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cfg_valid,
  input  logic [1:0] i_cfg_mode,
  output logic       o_cfg_ready,
  input  logic       i_per_frame_vsync,
  input  logic       i_per_frame_href,
  input  logic       i_per_frame_clken,
  output logic       o_ctrl_frame_vsync,
  output logic       o_ctrl_frame_href,
  output logic       o_ctrl_frame_clken,
  output logic [1:0] o_morph_mode,
  output logic [9:0] o_pix_x,
  output logic [9:0] o_pix_y,
  output logic       o_border_flag,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic [7:0] o_frame_cnt
);

  logic       w_vs_level, w_vs_rise, w_vs_fall;
  logic       w_hs_level, w_hs_rise, w_hs_fall;
  logic       w_unused;
  logic       w_accept, w_fs, w_fe, w_le, w_hs, w_border;
  logic [9:0] w_x_inc, w_y_inc;

  state_t     r_state;
  logic       r_armed;
  logic       r_ctrl_clken;
  logic [9:0] r_x, r_y;
  logic [9:0] r_pix_x, r_pix_y;
  logic       r_border;
  logic       r_cfg_ready;
  logic       r_pend_valid;
  logic [1:0] r_pend_mode;
  logic [1:0] r_morph_mode;
  logic       r_frame_done;
  logic       r_frame_err;
  logic [7:0] r_frame_cnt;

  vip_edge_detect u_vs_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_per_frame_vsync),
    .o_level (w_vs_level),
    .o_rise  (w_vs_rise),
    .o_fall  (w_vs_fall)
  );

  vip_edge_detect u_hs_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_per_frame_href),
    .o_level (w_hs_level),
    .o_rise  (w_hs_rise),
    .o_fall  (w_hs_fall)
  );

  assign w_unused = w_hs_rise;

  // A vsync already high out of reset must not open a frame: arm on a low level first.
  assign w_fs     = w_vs_rise & r_armed;
  assign w_fe     = w_vs_fall;
  assign w_le     = w_hs_fall | (w_fe & w_hs_level);
  assign w_accept = i_per_frame_href & i_per_frame_clken;
  assign w_hs     = i_cfg_valid & r_cfg_ready;
  assign w_x_inc  = w_accept ? sat_inc10(r_x) : r_x;
  assign w_y_inc  = w_le ? sat_inc10(r_y) : r_y;
  assign w_border = (r_x == 10'd0) | (r_x == IMG_HDISP - 10'd1) |
                    (r_y == 10'd0) | (r_y == IMG_VDISP - 10'd1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_ctrl_clken <= 1'b0;
      r_x          <= 10'd0;
      r_y          <= 10'd0;
      r_pix_x      <= 10'd0;
      r_pix_y      <= 10'd0;
      r_border     <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_pend_valid <= 1'b0;
      r_pend_mode  <= MODE_BYPASS;
      r_morph_mode <= MODE_BYPASS;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= 8'd0;
    end else begin
      r_armed      <= r_armed | ~i_per_frame_vsync;
      r_ctrl_clken <= i_per_frame_clken;
      r_pix_x      <= r_x;
      r_pix_y      <= r_y;
      r_border     <= (r_state == ST_ACTIVE) & w_accept & w_border;
      r_frame_done <= 1'b0;

      // Handshake only possible while pending is empty, so it never collides
      // with the pending->morph_mode transfer below.
      if (w_hs) begin
        r_pend_mode  <= i_cfg_mode;
        r_pend_valid <= 1'b1;
        r_cfg_ready  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_x <= 10'd0;
          r_y <= 10'd0;
          if (w_fs) begin
            r_state     <= ST_ACTIVE;
            r_frame_err <= 1'b0;
            if (r_pend_valid) begin
              r_morph_mode <= mode_effective(r_pend_mode);
              r_pend_valid <= 1'b0;
              r_cfg_ready  <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          r_x <= w_x_inc;
          if (w_le) begin
            if (w_x_inc != IMG_HDISP) r_frame_err <= 1'b1;
            r_x <= 10'd0;
            r_y <= w_y_inc;
          end
          if (w_fe) begin
            if (w_y_inc != IMG_VDISP) r_frame_err <= 1'b1;
            r_state      <= ST_IDLE;
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cfg_ready        = r_cfg_ready;
  assign o_ctrl_frame_vsync = w_vs_level;
  assign o_ctrl_frame_href  = w_hs_level;
  assign o_ctrl_frame_clken = r_ctrl_clken;
  assign o_morph_mode       = r_morph_mode;
  assign o_pix_x            = r_pix_x;
  assign o_pix_y            = r_pix_y;
  assign o_border_flag      = r_border;
  assign o_frame_done       = r_frame_done;
  assign o_frame_err        = r_frame_err;
  assign o_frame_cnt        = r_frame_cnt;

endmodule
